// File: rtl/regfile_wb_sched_pkg.sv
// Shared types and defaults for the regfile writeback scheduler.
package regfile_wb_sched_pkg;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic       valid;
        creg_addr_t wa;
        word_t      wd;
    } wb_req_t;

    localparam int STARVE_LIMIT_DEFAULT    = 3;
    localparam int MAX_OUTSTANDING_DEFAULT = 4;
endpackage

// File: rtl/regfile_wb_sched_wb_arbiter.sv
// Two-requester writeback arbiter: pipeline has priority, mul/div is forced
// through after STARVE_LIMIT consecutive losses.
module wb_arbiter
    import regfile_wb_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic pipe_valid,
    input  logic md_valid,
    output logic grant_pipe,
    output logic grant_md
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          force_md;

    assign force_md = (starve_cnt == CW'(STARVE_LIMIT));

    always_comb begin
        grant_md   = md_valid && (!pipe_valid || force_md);
        grant_pipe = pipe_valid && !grant_md;
    end

    // Counts only consecutive losses; any md win or idle md cycle restarts it.
    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (!md_valid || grant_md)
            starve_cnt <= '0;
        else if (!force_md)
            starve_cnt <= starve_cnt + CW'(1);
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// Regfile write-port scheduler with mul/div pending scoreboard and hazard report.
// Optional same-cycle writeback bypass enabled by defining WB_BYPASS_EN.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int STARVE_LIMIT    = STARVE_LIMIT_DEFAULT,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    output logic        pipe_ready,
    input  creg_addr_t  pipe_wa,
    input  word_t       pipe_wd,
    input  logic        md_issue,
    input  creg_addr_t  md_issue_wa,
    output logic        md_issue_ready,
    input  logic        md_valid,
    output logic        md_ready,
    input  creg_addr_t  md_wa,
    input  word_t       md_wd,
    output logic        rf_we,
    output creg_addr_t  rf_wa,
    output word_t       rf_wd,
    input  creg_addr_t  ra1,
    input  creg_addr_t  ra2,
    input  word_t       rd1_raw,
    input  word_t       rd2_raw,
    output word_t       rd1,
    output word_t       rd2,
    output logic        hz1,
    output logic        hz2,
    output logic [31:0] busy_mask
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic          grant_pipe, grant_md;
    logic          issue_ok;
    logic [OW-1:0] outstanding;
    logic [31:0]   busy_nxt;
    wb_req_t       sel;
    logic          wr1, wr2;

    wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .pipe_valid(pipe_valid),
        .md_valid  (md_valid),
        .grant_pipe(grant_pipe),
        .grant_md  (grant_md)
    );

    assign pipe_ready     = pipe_valid & grant_pipe;
    assign md_ready       = md_valid & grant_md;
    assign md_issue_ready = !busy_mask[md_issue_wa] && (outstanding < OW'(MAX_OUTSTANDING));
    assign issue_ok       = md_issue && md_issue_ready;

    always_comb begin
        sel = '0;
        if (pipe_ready)
            sel = '{valid: 1'b1, wa: pipe_wa, wd: pipe_wd};
        else if (md_ready)
            sel = '{valid: 1'b1, wa: md_wa, wd: md_wd};
    end

    // r0 writes complete the handshake but never reach the regfile.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= sel.valid && (sel.wa != '0);
            if (sel.valid) begin
                rf_wa <= sel.wa;
                rf_wd <= sel.wd;
            end
        end
    end

    // Clear applied before set so a same-edge issue to the same register wins.
    always_comb begin
        busy_nxt = busy_mask;
        if (md_ready)
            busy_nxt[md_wa] = 1'b0;
        if (issue_ok && md_issue_wa != '0)
            busy_nxt[md_issue_wa] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_mask   <= '0;
            outstanding <= '0;
        end else begin
            busy_mask <= busy_nxt;
            case ({issue_ok, md_ready})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   if (outstanding != '0) outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign wr1 = rf_we && (rf_wa == ra1) && (ra1 != '0);
    assign wr2 = rf_we && (rf_wa == ra2) && (ra2 != '0);

`ifdef WB_BYPASS_EN
    assign rd1 = wr1 ? rf_wd : rd1_raw;
    assign rd2 = wr2 ? rf_wd : rd2_raw;
    assign hz1 = (ra1 != '0) && busy_mask[ra1];
    assign hz2 = (ra2 != '0) && busy_mask[ra2];
`else
    // Without bypass the in-flight write is not yet visible, so decode stalls.
    assign rd1 = rd1_raw;
    assign rd2 = rd2_raw;
    assign hz1 = ((ra1 != '0) && busy_mask[ra1]) || wr1;
    assign hz2 = ((ra2 != '0) && busy_mask[ra2]) || wr2;
`endif
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with a queue of expected regfile writes.
module tb_regfile_wb_sched;
    import regfile_wb_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid, pipe_ready;
    creg_addr_t  pipe_wa;
    word_t       pipe_wd;
    logic        md_issue, md_issue_ready;
    creg_addr_t  md_issue_wa;
    logic        md_valid, md_ready;
    creg_addr_t  md_wa;
    word_t       md_wd;
    logic        rf_we;
    creg_addr_t  rf_wa;
    word_t       rf_wd;
    creg_addr_t  ra1, ra2;
    word_t       rd1_raw, rd2_raw, rd1, rd2;
    logic        hz1, hz2;
    logic [31:0] busy_mask;

    int tests = 0;
    int fails = 0;
    wb_req_t exp_q[$];

    always #5 clk = ~clk;

    regfile_wb_sched dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .md_issue(md_issue), .md_issue_wa(md_issue_wa), .md_issue_ready(md_issue_ready),
        .md_valid(md_valid), .md_ready(md_ready), .md_wa(md_wa), .md_wd(md_wd),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .ra1(ra1), .ra2(ra2), .rd1_raw(rd1_raw), .rd2_raw(rd2_raw),
        .rd1(rd1), .rd2(rd2), .hz1(hz1), .hz2(hz2), .busy_mask(busy_mask)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_valid = 0; md_valid = 0; md_issue = 0;
    endtask

    task automatic expect_wb(input logic we, input creg_addr_t wa, input word_t wd);
        exp_q.push_back('{valid: we, wa: wa, wd: wd});
    endtask

    // Compare the registered write port against the oldest expected write.
    task automatic check_wb(input string tag);
        wb_req_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_qempty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_we"}, {31'd0, rf_we}, {31'd0, e.valid});
            if (e.valid) begin
                chk({tag, "_wa"}, {27'd0, rf_wa}, {27'd0, e.wa});
                chk({tag, "_wd"}, rf_wd, e.wd);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; idle();
        pipe_wa = 0; pipe_wd = 0; md_wa = 0; md_wd = 0; md_issue_wa = 0;
        ra1 = 0; ra2 = 0; rd1_raw = 0; rd2_raw = 0;
        tick(); tick();
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_wa", {27'd0, rf_wa}, 32'd0);
        chk("rst_wd", rf_wd, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        reset = 0;
        tick();

        // Pipe-only write, latency one.
        pipe_valid = 1; pipe_wa = 5; pipe_wd = 32'h1234;
        #1;
        chk("pipe_ready", {31'd0, pipe_ready}, 32'd1);
        chk("pipe_md_ready", {31'd0, md_ready}, 32'd0);
        expect_wb(1, 5, 32'h1234);
        tick();
        pipe_valid = 0;
        check_wb("pipe_wb");
        tick();
        chk("nogrant_we", {31'd0, rf_we}, 32'd0);
        chk("nogrant_wa_hold", {27'd0, rf_wa}, 32'd5);
        chk("nogrant_wd_hold", rf_wd, 32'h1234);

        // Continuous contention: P,P,P,M,P.
        for (int i = 0; i < 5; i++) begin
            pipe_valid = 1; pipe_wa = 1; pipe_wd = 32'h100 + i;
            md_valid = 1; md_wa = 2; md_wd = 32'hA0 + i;
            #1;
            if (i == 3) begin
                chk($sformatf("starve%0d_md", i), {31'd0, md_ready}, 32'd1);
                chk($sformatf("starve%0d_pipe", i), {31'd0, pipe_ready}, 32'd0);
                expect_wb(1, 2, 32'hA0 + i);
            end else begin
                chk($sformatf("starve%0d_md", i), {31'd0, md_ready}, 32'd0);
                chk($sformatf("starve%0d_pipe", i), {31'd0, pipe_ready}, 32'd1);
                expect_wb(1, 1, 32'h100 + i);
            end
            tick();
            check_wb($sformatf("starve%0d_wb", i));
        end
        idle();
        tick();

        // Scoreboard set / reissue block / clear.
        md_issue = 1; md_issue_wa = 8;
        #1;
        chk("iss8_ready", {31'd0, md_issue_ready}, 32'd1);
        tick();
        md_issue = 0; ra1 = 8;
        #1;
        chk("iss8_busy", busy_mask, 32'h100);
        chk("iss8_hz1", {31'd0, hz1}, 32'd1);
        md_issue = 1; md_issue_wa = 8;
        #1;
        chk("reiss8_ready", {31'd0, md_issue_ready}, 32'd0);
        tick();
        md_issue = 0;
        md_valid = 1; md_wa = 8; md_wd = 32'h88;
        #1;
        chk("wb8_md_ready", {31'd0, md_ready}, 32'd1);
        expect_wb(1, 8, 32'h88);
        tick();
        md_valid = 0;
        check_wb("wb8");
        chk("wb8_busy", busy_mask, 32'h0);
`ifdef WB_BYPASS_EN
        chk("wb8_hz1_inflight", {31'd0, hz1}, 32'd0);
        chk("wb8_rd1_bypass", rd1, 32'h88);
`else
        chk("wb8_hz1_inflight", {31'd0, hz1}, 32'd1);
        chk("wb8_rd1_raw", rd1, 32'h0);
`endif
        tick();
        chk("wb8_hz1_done", {31'd0, hz1}, 32'd0);
        ra1 = 0;

        // Outstanding=1 via r10, then same-cycle issue r9 + writeback r9.
        md_issue = 1; md_issue_wa = 10;
        tick();
        md_issue = 1; md_issue_wa = 9;
        md_valid = 1; md_wa = 9; md_wd = 32'h99;
        #1;
        chk("same9_iss_ready", {31'd0, md_issue_ready}, 32'd1);
        chk("same9_md_ready", {31'd0, md_ready}, 32'd1);
        expect_wb(1, 9, 32'h99);
        tick();
        md_valid = 0;
        check_wb("same9_wb");
        chk("same9_busy", busy_mask, 32'h600);
        // Outstanding is 1, so exactly three more issues fit.
        for (int r = 11; r <= 13; r++) begin
            md_issue = 1; md_issue_wa = creg_addr_t'(r);
            #1;
            chk($sformatf("iss%0d_ready", r), {31'd0, md_issue_ready}, 32'd1);
            tick();
        end
        md_issue = 1; md_issue_wa = 14;
        #1;
        chk("iss14_full", {31'd0, md_issue_ready}, 32'd0);
        md_issue = 0;
        chk("full_busy", busy_mask, 32'h3E00);
        tick();

        // r0 writebacks from both sources.
        pipe_valid = 1; pipe_wa = 0; pipe_wd = 32'hDEAD;
        #1;
        chk("r0pipe_ready", {31'd0, pipe_ready}, 32'd1);
        expect_wb(0, 0, 0);
        tick();
        pipe_valid = 0;
        check_wb("r0pipe_wb");
        md_valid = 1; md_wa = 0; md_wd = 32'hFACE;
        #1;
        chk("r0md_ready", {31'd0, md_ready}, 32'd1);
        expect_wb(0, 0, 0);
        tick();
        md_valid = 0;
        check_wb("r0md_wb");

        // Pipe write to a busy register leaves the busy bit set.
        pipe_valid = 1; pipe_wa = 10; pipe_wd = 32'h1010;
        expect_wb(1, 10, 32'h1010);
        tick();
        pipe_valid = 0;
        check_wb("pipe10_wb");
        chk("pipe10_busy", busy_mask, 32'h3E00);

        // Same-cycle read of the register being written.
        pipe_valid = 1; pipe_wa = 3; pipe_wd = 32'hBEEF;
        expect_wb(1, 3, 32'hBEEF);
        tick();
        pipe_valid = 0;
        check_wb("bypass_wb");
        ra2 = 3; rd2_raw = 32'h0;
        #1;
`ifdef WB_BYPASS_EN
        chk("bypass_rd2", rd2, 32'hBEEF);
        chk("bypass_hz2", {31'd0, hz2}, 32'd0);
`else
        chk("bypass_rd2", rd2, 32'h0);
        chk("bypass_hz2", {31'd0, hz2}, 32'd1);
`endif
        ra2 = 0;

        // Reset mid-operation with a request pending and busy bits set.
        pipe_valid = 1; pipe_wa = 4; pipe_wd = 32'h4444;
        reset = 1;
        tick();
        idle();
        chk("midrst_busy", busy_mask, 32'h0);
        chk("midrst_we", {31'd0, rf_we}, 32'd0);
        reset = 0;
        md_issue_wa = 14;
        #1;
        chk("midrst_iss_ready", {31'd0, md_issue_ready}, 32'd1);
        chk("q_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Schedules the single register-file write port between two writeback sources:
  - the in-order pipeline writeback stage;
  - the multi-cycle mul/div unit.
- Keeps a per-register pending scoreboard for long-latency destinations and reports read hazards to decode.
- Sits between the writeback stage / mul-div unit and the regfile write port (wa/wd/we).

Parameters:
- STARVE_LIMIT, 3: consecutive cycles a valid md request may lose arbitration before it is forced to win.
- MAX_OUTSTANDING, 4: maximum number of mul/div ops issued but not yet written back.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- pipe_valid  in  1  pipeline writeback request
- pipe_ready  out  1  pipeline request accepted this cycle
- pipe_wa  in  5  pipeline destination (creg_addr_t)
- pipe_wd  in  32  pipeline write data (word_t)
- md_issue  in  1  mul/div op issued this cycle
- md_issue_wa  in  5  destination of the issued op
- md_issue_ready  out  1  issue permitted this cycle
- md_valid  in  1  mul/div writeback request
- md_ready  out  1  mul/div request accepted this cycle
- md_wa  in  5  mul/div destination
- md_wd  in  32  mul/div data
- rf_we  out  1  regfile write enable
- rf_wa  out  5  regfile write address
- rf_wd  out  32  regfile write data
- ra1, ra2  in  5  decode read addresses
- rd1_raw, rd2_raw  in  32  regfile read data
- rd1, rd2  out  32  read data after optional bypass
- hz1, hz2  out  1  read hazard (decode must stall)
- busy_mask  out  32  scoreboard bits

Behaviour:
- Reset state: rf_we=0, rf_wa=0, rf_wd=0, busy_mask=0, starvation counter=0, outstanding counter=0.
  - Reset asserted mid-operation discards all pending state; no write is emitted in the following cycle.
- Arbitration (combinational grant):
  - Default: pipe wins when both pipe_valid and md_valid are high.
  - If starve_cnt==STARVE_LIMIT and md_valid is high, md wins and pipe_ready=0.
  - pipe_ready = pipe_valid & grant_pipe; md_ready = md_valid & grant_md.
  - At most one ready per cycle.
- Starvation counter:
  - Increments while md_valid is high and md loses.
  - Resets to 0 when md wins or md_valid is low.
  - Saturates at STARVE_LIMIT.
- Write port is registered, latency 1:
  - The accepted request at edge N appears on rf_we/rf_wa/rf_wd in cycle N+1.
  - The regfile commits it at edge N+1.
  - No grant: rf_we=0, rf_wa/rf_wd hold their last value.
  - Accepted request with wa==0: handshake completes but rf_we=0.
- Scoreboard:
  - md_issue with md_issue_ready sets busy[md_issue_wa]; issue to r0 is accepted but sets nothing.
  - An accepted md writeback clears busy[md_wa] at the acceptance edge.
  - Same edge set and clear of the same register: set wins.
  - md_issue_ready = !busy[md_issue_wa] && outstanding < MAX_OUTSTANDING.
- Outstanding counter:
  - +1 on an accepted issue, -1 on an accepted md writeback.
  - Both in the same cycle: unchanged.
- Hazards: hz1 = (ra1!=0) && busy[ra1]; hz2 likewise for ra2. Purely combinational.
- An accepted pipe writeback to a busy register does not clear the busy bit (WAW ordering belongs to the issuer).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: rd1 = rf_wd when rf_we && rf_wa==ra1 && ra1!=0, else rd1_raw; rd2 likewise. This covers the same-cycle read of the register being written.
- Undefined:
  - rd1/rd2 pass through rd*_raw unchanged.
  - hz1 additionally asserts when rf_we && rf_wa==ra1 && ra1!=0; hz2 likewise.

Decomposition:
- Package common:
  - creg_addr_t, word_t.
  - New wb_req_t struct {valid, wa, wd}.
  - STARVE_LIMIT_DEFAULT constant.
- Sub-module wb_arbiter: two-requester priority and starvation logic, outputs the grant.
- The scoreboard, output register and bypass logic stay in the top module.

Test Plan:
- Pipe only, wa=5, wd=0x1234 -> pipe_ready=1 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0x1234.
- Both valid continuously, STARVE_LIMIT=3 -> pipe wins 3 cycles, md wins on the 4th cycle (md_ready=1, pipe_ready=0), then counter restarts.
- md_issue wa=8 -> busy_mask=0x100; ra1=8 gives hz1=1.
  - Second issue to r8 -> md_issue_ready=0.
  - md writeback r8 accepted -> bit clears, hz1=0.
- Issue r9 and md writeback of r9 in the same cycle -> busy[9] stays 1, outstanding count unchanged.
- Writeback to r0 from either source -> handshake completes, rf_we stays 0.
- With WB_BYPASS_EN: rf_we=1, rf_wa=3, rf_wd=0xBEEF, ra2=3, rd2_raw=0 -> rd2=0xBEEF, hz2=0.
  - Without WB_BYPASS_EN, same stimulus -> hz2=1, rd2=0.
  - Reset asserted mid-sequence -> next cycle busy_mask=0, rf_we=0.
